// File: rtl/data_mem_lanes_if.sv
// Request/response handshake bundle for the
// byte-lane data memory.
interface data_mem_lanes_if #(
  parameter int LANES  = 4,
  parameter int ADDR_W = 12
);
  logic               req_valid;
  logic               req_ready;
  logic               req_we;
  logic [1:0]         req_size;
  logic               req_signed;
  logic [ADDR_W-1:0]  req_addr;
  logic [8*LANES-1:0] req_wdata;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [8*LANES-1:0] rsp_data;
  logic               rsp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_signed, req_addr, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_signed, req_addr, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output rsp_data, rsp_err
  );
endinterface

// File: rtl/data_mem_lanes.sv
// MEM-stage data memory built from LANES byte
// banks with sized, aligned-or-not access.
module data_mem_lanes #(
  parameter int LANES            = 4,
  parameter int ADDR_W           = 12,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               halt,
  data_mem_lanes_if.slave    bus,
  input  logic               init_en,
  input  logic [ADDR_W-1:0]  init_addr,
  input  logic [8*LANES-1:0] init_data1,
  input  logic [8*LANES-1:0] init_data2,
  input  logic               clear_start,
  output logic               clear_busy,
  output logic               clear_done
);
  localparam int OFF_W = $clog2(LANES);
  localparam int ROW_W = ADDR_W - OFF_W;
  localparam int DEPTH = 1 << ROW_W;
  localparam int DW    = 8 * LANES;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  typedef struct packed {
    logic [OFF_W-1:0] off;
    logic [1:0]       size;
    logic             sgn;
    logic             ld;
  } meta_t;

  state_t           state;
  state_t           state_nx;
  logic [ROW_W-1:0] row_cnt;
  logic             done_q;
  meta_t            meta_q;
  logic             rsp_valid_q;
  logic             rsp_err_q;

  logic             accept;
  logic             init_wr;
  logic             clr_wr;
  logic             req_err;
  logic             misal;
  logic [OFF_W-1:0] a_off;
  logic [ROW_W-1:0] a_row;
  logic [ROW_W-1:0] i_row;
  logic [ADDR_W-1:0] size_mask;
  logic [DW-1:0]    rd_all;
  logic [DW-1:0]    raw;
  logic [DW-1:0]    data;
  logic [OFF_W-1:0] ri;
  logic [OFF_W-1:0] sgn_idx;
  logic             sgn;
  logic             unused_init_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (!halt) state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:
        if (clear_start) state_nx = CLEAR;
      CLEAR:
        if (row_cnt == ROW_W'(DEPTH - 1))
          state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    clear_busy    = 1'b0;
    bus.req_ready = 1'b0;
    init_wr       = 1'b0;
    clr_wr        = 1'b0;
    unique case (state)
      IDLE: begin
        bus.req_ready = !halt && !init_en &&
                        !clear_start &&
                        (!rsp_valid_q || bus.rsp_ready);
        init_wr = init_en && !halt && !clear_start;
      end
      CLEAR: begin
        clear_busy = 1'b1;
        clr_wr     = !halt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
      done_q  <= 1'b0;
    end else if (!halt) begin
      if (clr_wr) row_cnt <= row_cnt + ROW_W'(1);
      done_q <= clr_wr &&
                (row_cnt == ROW_W'(DEPTH - 1));
    end
  end

  assign accept    = bus.req_valid && bus.req_ready;
  assign a_off     = bus.req_addr[OFF_W-1:0];
  assign a_row     = bus.req_addr[ADDR_W-1:OFF_W];
  assign i_row     = init_addr[ADDR_W-1:OFF_W];
  assign size_mask = (ADDR_W'(1) << bus.req_size)
                     - ADDR_W'(1);
  assign misal     = |(bus.req_addr & size_mask);
  assign req_err   = (int'(bus.req_size) > OFF_W) ||
                     (!ALLOW_MISALIGNED && misal);

  assign unused_init_lo = ^init_addr[OFF_W-1:0];

  // Each bank sees request byte idx; banks below
  // the start offset belong to the next row.
  for (genvar b = 0; b < LANES; b++) begin : g_bank
    logic [7:0]       mem [DEPTH];
    logic [7:0]       rd;
    logic [OFF_W-1:0] idx;
    logic [ROW_W-1:0] row;
    logic             hit;

    assign idx = OFF_W'(b) - a_off;
    assign hit = (idx >> bus.req_size) == '0;
    assign row = a_row +
                 ROW_W'(OFF_W'(b) < a_off);

    always_ff @(posedge clk) begin
      if (clr_wr) begin
        mem[row_cnt] <= '0;
      end else if (init_wr) begin
        mem[i_row] <= init_data1[8*b +: 8];
        mem[i_row + ROW_W'(1)] <=
          init_data2[8*b +: 8];
      end else if (accept && hit && !req_err) begin
        if (bus.req_we)
          mem[row] <= bus.req_wdata[{idx, 3'b000} +: 8];
        else
          rd <= mem[row];
      end
    end

    assign rd_all[8*b +: 8] = rd;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      meta_q      <= '0;
    end else if (!halt) begin
      if (accept) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= req_err;
        meta_q.off  <= a_off;
        meta_q.size <= bus.req_size;
        meta_q.sgn  <= bus.req_signed;
        meta_q.ld   <= !bus.req_we && !req_err;
      end else if (bus.rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  always_comb begin
    raw     = '0;
    data    = '0;
    ri      = '0;
    sgn_idx = '0;
    sgn     = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      ri = meta_q.off + OFF_W'(i);
      raw[8*i +: 8] = rd_all[{ri, 3'b000} +: 8];
    end
    sgn_idx = OFF_W'((32'd1 << meta_q.size) - 32'd1);
    sgn = meta_q.sgn && raw[{sgn_idx, 3'b111}];
    for (int i = 0; i < LANES; i++) begin
      ri = OFF_W'(i);
      if ((ri >> meta_q.size) == '0)
        data[8*i +: 8] = raw[8*i +: 8];
      else
        data[8*i +: 8] = {8{sgn}};
    end
  end

  assign bus.rsp_data  = meta_q.ld ? data : '0;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign clear_done    = done_q;
endmodule

// File: tb/tb_data_mem_lanes.sv
// Bench for data_mem_lanes: directed steps plus
// random traffic against a byte-array model.
module tb_data_mem_lanes;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt, halt0;
  logic        init_en, init_en0;
  logic [11:0] init_addr;
  logic [31:0] init_data1, init_data2;
  logic        clear_start, clear_start0;
  logic        clear_busy, clear_busy0;
  logic        clear_done, clear_done0;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_m  [4096];
  logic [7:0] mem0_m [4096];

  data_mem_lanes_if #(.LANES(4), .ADDR_W(12)) m ();
  data_mem_lanes_if #(.LANES(4), .ADDR_W(12)) m0 ();

  data_mem_lanes #(
    .LANES(4), .ADDR_W(12), .ALLOW_MISALIGNED(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .halt(halt), .bus(m),
    .init_en(init_en), .init_addr(init_addr),
    .init_data1(init_data1), .init_data2(init_data2),
    .clear_start(clear_start),
    .clear_busy(clear_busy), .clear_done(clear_done)
  );

  data_mem_lanes #(
    .LANES(4), .ADDR_W(12), .ALLOW_MISALIGNED(1'b0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .halt(halt0), .bus(m0),
    .init_en(init_en0), .init_addr(init_addr),
    .init_data1(init_data1), .init_data2(init_data2),
    .clear_start(clear_start0),
    .clear_busy(clear_busy0), .clear_done(clear_done0)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mdl_load(
      input bit z, input logic [1:0] sz,
      input bit sg, input logic [11:0] a);
    int n;
    logic [31:0] r;
    n = 1 << sz;
    r = '0;
    for (int i = 0; i < n; i++)
      r[8*i +: 8] = z ? mem0_m[(a + i) % 4096]
                      : mem_m[(a + i) % 4096];
    if (sg && n < 4 && r[8*n-1])
      r = r | (32'hFFFF_FFFF << (8*n));
    return r;
  endfunction

  task automatic drive(input bit z, input bit we,
                       input logic [1:0] sz,
                       input bit sg,
                       input logic [11:0] a,
                       input logic [31:0] wd);
    if (!z) begin
      m.req_valid = 1'b1; m.req_we = we;
      m.req_size = sz; m.req_signed = sg;
      m.req_addr = a; m.req_wdata = wd;
    end else begin
      m0.req_valid = 1'b1; m0.req_we = we;
      m0.req_size = sz; m0.req_signed = sg;
      m0.req_addr = a; m0.req_wdata = wd;
    end
  endtask

  task automatic xact(input bit z, input bit we,
                      input logic [1:0] sz,
                      input bit sg,
                      input logic [11:0] a,
                      input logic [31:0] wd,
                      output logic [31:0] d,
                      output logic e);
    int n;
    drive(z, we, sz, sg, a, wd);
    m.rsp_ready = 1'b1;
    m0.rsp_ready = 1'b1;
    n = 0;
    #1;
    while (!(z ? m0.req_ready : m.req_ready) && n < 64)
    begin
      @(posedge clk); #1; n++;
    end
    chk("req_ready_wait", 32'(n < 64), 32'd1);
    @(posedge clk); #1;
    m.req_valid = 1'b0;
    m0.req_valid = 1'b0;
    chk("rsp_valid", z ? m0.rsp_valid : m.rsp_valid,
        32'd1);
    d = z ? m0.rsp_data : m.rsp_data;
    e = z ? m0.rsp_err : m.rsp_err;
  endtask

  task automatic run(input bit z, input bit we,
                     input logic [1:0] sz, input bit sg,
                     input logic [11:0] a,
                     input logic [31:0] wd,
                     input string tag);
    logic [31:0] d, exp_d;
    logic        e, exp_e;
    int n;
    n = 1 << sz;
    exp_e = (sz == 2'd3) || (z && (a % n) != 0);
    exp_d = '0;
    if (!exp_e && !we) exp_d = mdl_load(z, sz, sg, a);
    xact(z, we, sz, sg, a, wd, d, e);
    chk({tag, "_err"}, 32'(e), 32'(exp_e));
    chk({tag, "_data"}, d, exp_d);
    if (!exp_e && we)
      for (int i = 0; i < n; i++)
        if (z) mem0_m[(a + i) % 4096] = wd[8*i +: 8];
        else   mem_m[(a + i) % 4096]  = wd[8*i +: 8];
  endtask

  task automatic ld_const(input logic [1:0] sz,
                          input bit sg,
                          input logic [11:0] a,
                          input logic [31:0] expv,
                          input string tag);
    logic [31:0] d;
    logic        e;
    xact(1'b0, 1'b0, sz, sg, a, 32'd0, d, e);
    chk({tag, "_err"}, 32'(e), 32'd0);
    chk(tag, d, expv);
  endtask

  initial begin
    logic [31:0] d, pend;
    logic        e;
    logic [11:0] a;
    logic [31:0] bexp [4];
    logic [11:0] baddr [4];
    logic [1:0]  bsz [4];
    int cnt;
    bit seen;

    rst_n = 1'b0;
    halt = 0; halt0 = 0;
    init_en = 0; init_en0 = 0;
    init_addr = '0; init_data1 = '0; init_data2 = '0;
    clear_start = 0; clear_start0 = 0;
    m.req_valid = 0; m.req_we = 0; m.req_size = '0;
    m.req_signed = 0; m.req_addr = '0;
    m.req_wdata = '0; m.rsp_ready = 0;
    m0.req_valid = 0; m0.req_we = 0; m0.req_size = '0;
    m0.req_signed = 0; m0.req_addr = '0;
    m0.req_wdata = '0; m0.rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_valid", 32'(m.rsp_valid), 32'd0);
    chk("rst_rsp_data", m.rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(m.rsp_err), 32'd0);
    chk("rst_clear_busy", 32'(clear_busy), 32'd0);
    chk("rst_clear_done", 32'(clear_done), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero both memories so the model starts known.
    clear_start = 1; clear_start0 = 1;
    @(posedge clk); #1;
    clear_start = 0; clear_start0 = 0;
    cnt = 0;
    while (!clear_done && cnt < 1100) begin
      @(posedge clk); #1; cnt++;
    end
    chk("init_clear_len", cnt, 32'd1024);
    chk("init_clear_done0", 32'(clear_done0), 32'd1);
    for (int i = 0; i < 4096; i++) begin
      mem_m[i] = 8'h00; mem0_m[i] = 8'h00;
    end

    run(0, 1, 2'd2, 0, 12'h005, 32'hA1B2C3D4, "st_w5");
    ld_const(2'd0, 0, 12'h005, 32'h0000_00D4, "ldb5");
    ld_const(2'd0, 0, 12'h008, 32'h0000_00A1, "ldb8");
    ld_const(2'd2, 0, 12'h005, 32'hA1B2C3D4, "ldw5");
    ld_const(2'd0, 0, 12'h004, 32'h0000_0000, "ldb4");
    ld_const(2'd1, 1, 12'h006, 32'hFFFF_B2C3, "ldhs6");
    ld_const(2'd1, 0, 12'h006, 32'h0000_B2C3, "ldhu6");
    run(0, 1, 2'd2, 0, 12'hFFE, 32'h01020304, "st_wrap");
    ld_const(2'd0, 0, 12'hFFE, 32'h04, "wrap_ffe");
    ld_const(2'd0, 0, 12'hFFF, 32'h03, "wrap_fff");
    ld_const(2'd0, 0, 12'h000, 32'h02, "wrap_000");
    ld_const(2'd0, 0, 12'h001, 32'h01, "wrap_001");

    init_en = 1; init_addr = 12'h010;
    init_data1 = 32'h11223344; init_data2 = 32'h55667788;
    drive(0, 0, 2'd2, 0, 12'h012, 32'd0);
    #1;
    chk("init_req_ready", 32'(m.req_ready), 32'd0);
    @(posedge clk); #1;
    init_en = 0; m.req_valid = 0;
    chk("init_no_rsp", 32'(m.rsp_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      mem_m[16 + i] = init_data1[8*i +: 8];
      mem_m[20 + i] = init_data2[8*i +: 8];
    end
    ld_const(2'd2, 0, 12'h012, 32'h77881122, "init_w12");

    for (int k = 0; k < 150; k++) begin
      a = ($urandom % 2) ? 12'($urandom_range(0, 31))
                         : 12'($urandom_range(4064, 4095));
      run(0, 1'($urandom % 2), 2'($urandom % 4),
          1'($urandom % 2), a, $urandom, "rnd");
    end

    // Back-pressure: response must hold while stalled.
    pend = mdl_load(0, 2'd2, 0, 12'h005);
    drive(0, 0, 2'd2, 0, 12'h005, 32'd0);
    m.rsp_ready = 1; #1;
    @(posedge clk); #1;
    m.req_valid = 0; m.rsp_ready = 0;
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 2'd0, 0, 12'h00A, 32'd0);
      #1;
      chk("bp_valid", 32'(m.rsp_valid), 32'd1);
      chk("bp_data", m.rsp_data, pend);
      chk("bp_ready", 32'(m.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    m.req_valid = 0; m.rsp_ready = 1;
    @(posedge clk); #1;
    chk("bp_single", 32'(m.rsp_valid), 32'd0);

    for (int k = 0; k < 4; k++) begin
      baddr[k] = 12'($urandom_range(0, 31));
      bsz[k] = 2'($urandom % 3);
      bexp[k] = mdl_load(0, bsz[k], 0, baddr[k]);
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, bsz[k], 0, baddr[k], 32'd0);
      #1;
      chk("b2b_ready", 32'(m.req_ready), 32'd1);
      @(posedge clk); #1;
      chk("b2b_valid", 32'(m.rsp_valid), 32'd1);
      chk("b2b_data", m.rsp_data, bexp[k]);
    end
    m.req_valid = 0;
    @(posedge clk); #1;
    chk("b2b_end", 32'(m.rsp_valid), 32'd0);

    // Clear with a halted stretch and a pending load.
    pend = mdl_load(0, 2'd2, 0, 12'h014);
    drive(0, 0, 2'd2, 0, 12'h014, 32'd0);
    m.rsp_ready = 1; #1;
    @(posedge clk); #1;
    m.req_valid = 0; m.rsp_ready = 0;
    clear_start = 1;
    @(posedge clk); #1;
    clear_start = 0;
    chk("clr_busy", 32'(clear_busy), 32'd1);
    cnt = 0;
    while (!clear_done && cnt < 1100) begin
      @(posedge clk); #1; cnt++;
      if (cnt == 100) halt = 1;
      if (cnt == 103)
        chk("halt_hold", 32'(m.rsp_valid), 32'd1);
      if (cnt == 105) halt = 0;
      if (cnt == 1028)
        chk("clr_busy_end", 32'(clear_busy), 32'd1);
    end
    chk("clr_len", cnt, 32'd1029);
    chk("clr_busy_off", 32'(clear_busy), 32'd0);
    @(posedge clk); #1;
    chk("clr_pulse", 32'(clear_done), 32'd0);
    chk("clr_pend_valid", 32'(m.rsp_valid), 32'd1);
    chk("clr_pend_data", m.rsp_data, pend);
    m.rsp_ready = 1;
    @(posedge clk); #1;
    chk("clr_pend_gone", 32'(m.rsp_valid), 32'd0);
    for (int i = 0; i < 4096; i++) mem_m[i] = 8'h00;
    for (int k = 0; k < 8; k++)
      ld_const(2'd0, 0, 12'($urandom % 4096),
               32'd0, "clr_zero");

    run(1, 1, 2'd2, 0, 12'h000, 32'hCAFEBABE, "m0_st0");
    run(1, 1, 2'd2, 0, 12'h002, 32'h12345678, "m0_mis");
    run(1, 0, 2'd2, 0, 12'h000, 32'd0, "m0_ld0");
    xact(1, 0, 2'd2, 0, 12'h000, 32'd0, d, e);
    chk("m0_unchanged", d, 32'hCAFEBABE);
    xact(1, 0, 2'd3, 0, 12'h000, 32'd0, d, e);
    chk("m0_sz3_err", 32'(e), 32'd1);
    chk("m0_sz3_data", d, 32'd0);
    for (int k = 0; k < 60; k++)
      run(1, 1'($urandom % 2), 2'($urandom % 4),
          1'($urandom % 2), 12'($urandom_range(0, 15)),
          $urandom, "m0_rnd");

    // Reset in the middle of a clear and a response.
    drive(0, 0, 2'd0, 0, 12'h001, 32'd0);
    m.rsp_ready = 1; #1;
    @(posedge clk); #1;
    m.req_valid = 0; m.rsp_ready = 0;
    clear_start = 1;
    @(posedge clk); #1;
    clear_start = 0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 0;
    #1;
    chk("rstc_busy", 32'(clear_busy), 32'd0);
    chk("rstc_rsp", 32'(m.rsp_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    seen = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (clear_done || clear_busy) seen = 1;
    end
    chk("rstc_no_done", 32'(seen), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_lanes.md
# data_mem_lanes

Parametrised byte-lane data memory for the processor's MEM stage, replacing the fixed 4-byte, 4096-row unaligned store/load array. It supports configurable lane count and depth, sized and sign-extended accesses, misalignment policy, and valid/ready request and response handshakes. It also provides a double-rate debug init port and a hardware clear sequencer. Storage is LANES independent byte banks, so any access up to one word completes in one bank cycle regardless of alignment.

## Interface
- LANES, 4, bytes per word; power of two, >= 2
- ADDR_W, 12, byte address width; rows per bank DEPTH = 2^ADDR_W / LANES
- ALLOW_MISALIGNED, 1, 1: unaligned accesses allowed; 0: they return an error
- Clk  in  1  clock, rising edge
- Rst_n  in  1  asynchronous active-low reset
- halt  in  1  freeze: no bank enable, no state/counter/output change
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid & req_ready
- req_we  in  1  1 store, 0 load
- req_size  in  2  access is 2^req_size bytes
- req_signed  in  1  sign-extend load result
- req_addr  in  ADDR_W  byte address
- req_wdata  in  8*LANES  store data, low 8*n bits used
- rsp_valid  out  1  response held until rsp_ready
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready
- rsp_data  out  8*LANES  load result; 0 for stores and errors
- rsp_err  out  1  illegal size or disallowed misalignment
- init_en  in  1  debug init write, one cycle = two words
- init_addr  in  ADDR_W  low log2(LANES) bits ignored
- init_data1, init_data2  in  8*LANES  words written at init_addr and init_addr+LANES
- clear_start  in  1  start zeroing all rows
- clear_busy  out  1  clear sequence running
- clear_done  out  1  one-cycle pulse on clear completion

## Operation
- Byte at address a lives in bank a mod LANES, row a / LANES. Access of n bytes at a touches bytes a..a+n-1 modulo 2^ADDR_W; wrap past the top goes to row 0.
- Request byte i maps to data bits [8i+7:8i], little-endian.
- Each bank computes its own row and write enable per access. At most one row per bank.
- Store: writes only the n addressed bytes; other bytes are unchanged.
- Load: n bytes in low bits. Upper bits are 0, or copies of bit 8n-1 when req_signed.
- Error (rsp_err=1, rsp_data=0, no write):
  - req_size > log2(LANES)
  - ALLOW_MISALIGNED=0 and a mod n != 0
- Every accepted request, load or store, produces exactly one response.
- FSM states:
  - IDLE: serves requests and init.
    - IDLE->CLEAR on clear_start & !halt. clear_start has priority over init and requests.
  - CLEAR: row counter 0..DEPTH-1 writes zero to all banks, one row per un-halted cycle.
    - CLEAR->IDLE after row DEPTH-1; clear_done pulses in the first IDLE cycle.
    - clear_start and init_en are ignored in CLEAR.
- Init: in IDLE, a cycle with init_en & !halt & !clear_start writes full words.
  - init_data1 goes to row r = init_addr/LANES; init_data2 goes to row (r+1) mod DEPTH.
  - Uses the banks' second port; no response is generated.
- req_ready = (state==IDLE) & !halt & !init_en & !clear_start & (!rsp_valid | rsp_ready). It is combinational from these signals only, never from req_valid.
- A pending response survives a clear sequence and is held until consumed.
- Reset mid-clear: FSM goes to IDLE, no clear_done pulse, memory partially cleared.
- Reset mid-response: the response is dropped.
- Memory contents are not affected by reset.

## Timing
- Reset values: rsp_valid 0, rsp_data 0, rsp_err 0, clear_busy 0, clear_done 0, FSM IDLE, row counter 0.
- Banks read synchronously. An accepted load at edge k gives rsp_valid=1 with data after edge k (latency 1); stores and errors likewise.
- Back-to-back accepts are allowed when rsp_ready is high: one request per cycle, full throughput.
- While rsp_valid & !rsp_ready: rsp_data and rsp_err are stable, and req_ready=0.
- A store followed next cycle by a load of the same byte returns the new value.
- Clear: clear_start sampled at edge k, so clear_busy=1 from k to k+DEPTH and clear_done=1 for one cycle after edge k+DEPTH. Each halted cycle adds one cycle.
- Init write commits at the edge where it is sampled; a load accepted on the next cycle sees it.
- halt high: bank enables are gated, and all registers hold, including rsp_valid/rsp_data.

## Test plan
- LANES=4, ADDR_W=12:
  - Store word 0xA1B2C3D4 @0x005 -> byte loads @0x005=0xD4, @0x008=0xA1; word load @0x005=0xA1B2C3D4; byte @0x004 unchanged.
  - Then signed half load @0x006 -> 0xFFFFB2C3; unsigned -> 0x0000B2C3.
  - Store word 0x01020304 @0xFFE -> bytes @0xFFE=0x04, 0xFFF=0x03, 0x000=0x02, 0x001=0x01 (wrap).
- Init 0x010, data1 0x11223344, data2 0x55667788 -> word @0x012 = 0x77881122; req_ready=0 during init_en.
- Load with rsp_ready low 3 cycles -> rsp_data stable, req_ready=0, one response only. Then 4 back-to-back loads with rsp_ready=1 -> 4 responses, in order, each 1 cycle after accept.
- clear_start at edge k, halt 5 cycles mid-run -> clear_done after edge k+1029. Every sampled byte reads 0. A pending response is still delivered after the clear.
- ALLOW_MISALIGNED=0: store word @0x002 -> rsp_err=1, rsp_data=0, memory unchanged; req_size=3 -> rsp_err=1. Reset asserted mid-clear -> clear_busy=0 immediately, no clear_done pulse.
